// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, data width and sequencer FSM states.
package alu_pkg;

   localparam int ALU_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_MUL = 3'b010,
      ALU_EQ  = 3'b011,
      ALU_GT  = 3'b100
   } alu_opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } seq_state_e;

   // Encodings above ALU_GT are reserved and never reach the ALU.
   function automatic logic is_legal_opcode(input logic [2:0] opcode);
      return opcode <= ALU_GT;
   endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Initiator for a registered ALU: accepts one request at a time, holds the ALU
// inputs for ALU_LATENCY edges, then returns the captured result over valid/ready.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
   parameter int ALU_LATENCY = 2,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock_in,
   input  logic                   reset_in,
   input  logic                   req_valid_in,
   output logic                   req_ready_out,
   input  logic [2:0]             req_opcode_in,
   input  logic [DATA_WIDTH-1:0]  req_a_in,
   input  logic [DATA_WIDTH-1:0]  req_b_in,
   output logic                   alu_enable_out,
   output logic [2:0]             alu_opcode_out,
   output logic [DATA_WIDTH-1:0]  alu_input1_out,
   output logic [DATA_WIDTH-1:0]  alu_input2_out,
   input  logic [DATA_WIDTH-1:0]  alu_output_in,
   output logic                   resp_valid_out,
   input  logic                   resp_ready_in,
   output logic [DATA_WIDTH-1:0]  resp_result_out,
   output logic [2:0]             resp_opcode_out,
   output logic                   resp_error_out,
   output logic [COUNT_WIDTH-1:0] op_count_out,
   output logic [7:0]             error_count_out
);

   localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

   seq_state_e state;
   logic [3:0] lat_cnt;

   // NOTE: every output is a flop written with <= in this one block, so all
   // outputs change together on the edge and reset clears them without a clock.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         state           <= ST_IDLE;
         lat_cnt         <= '0;
         req_ready_out   <= 1'b1;
         alu_enable_out  <= 1'b0;
         alu_opcode_out  <= '0;
         alu_input1_out  <= '0;
         alu_input2_out  <= '0;
         resp_valid_out  <= 1'b0;
         resp_result_out <= '0;
         resp_opcode_out <= '0;
         resp_error_out  <= 1'b0;
         op_count_out    <= '0;
         error_count_out <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_in) begin
                  req_ready_out <= 1'b0;
                  if (is_legal_opcode(req_opcode_in)) begin
                     alu_opcode_out <= req_opcode_in;
                     alu_input1_out <= req_a_in;
                     alu_input2_out <= req_b_in;
                     alu_enable_out <= 1'b1;
                     lat_cnt        <= LAT_LOAD;
                     state          <= ST_WAIT;
                  end else begin
                     // Illegal requests bypass the ALU entirely.
                     resp_error_out  <= 1'b1;
                     resp_result_out <= '0;
                     resp_opcode_out <= req_opcode_in;
                     resp_valid_out  <= 1'b1;
                     if (error_count_out != 8'hFF)
                        error_count_out <= error_count_out + 8'd1;
                     state <= ST_RESP;
                  end
               end
            end

            ST_WAIT: begin
               lat_cnt <= lat_cnt - 4'd1;
               if (lat_cnt == 4'd1) begin
                  resp_result_out <= alu_output_in;
                  resp_opcode_out <= alu_opcode_out;
                  resp_error_out  <= 1'b0;
                  resp_valid_out  <= 1'b1;
                  alu_enable_out  <= 1'b0;
                  state           <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (resp_ready_in) begin
                  resp_valid_out <= 1'b0;
                  op_count_out   <= op_count_out + COUNT_WIDTH'(1);
                  req_ready_out  <= 1'b1;
                  state          <= ST_IDLE;
               end
            end

            default: begin
               state          <= ST_IDLE;
               req_ready_out  <= 1'b1;
               alu_enable_out <= 1'b0;
               resp_valid_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a one-stage registered ALU stand-in;
// a second instance with a 4-bit counter exposes op_count wrap-around.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   logic       clock_in = 1'b0;
   logic       reset_in;
   logic       req_valid_in;
   logic [2:0] req_opcode_in;
   logic [7:0] req_a_in, req_b_in;
   logic       resp_ready_in;

   logic        req_ready_out, alu_enable_out, resp_valid_out, resp_error_out;
   logic [2:0]  alu_opcode_out, resp_opcode_out;
   logic [7:0]  alu_input1_out, alu_input2_out, resp_result_out, error_count_out;
   logic [15:0] op_count_out;
   logic [7:0]  alu_model_q;

   logic        s_req_ready, s_alu_enable, s_resp_valid, s_resp_error;
   logic [2:0]  s_alu_opcode, s_resp_opcode;
   logic [7:0]  s_alu_input1, s_alu_input2, s_resp_result, s_error_count;
   logic [3:0]  s_op_count;

   int checks = 0;
   int errors = 0;
   int exp_ops = 0;
   logic saw_enable;

   always #5 clock_in = ~clock_in;

   alu_op_sequencer #(.DATA_WIDTH(8), .ALU_LATENCY(2), .COUNT_WIDTH(16)) dut (
      .clock_in(clock_in), .reset_in(reset_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_opcode_in(req_opcode_in), .req_a_in(req_a_in), .req_b_in(req_b_in),
      .alu_enable_out(alu_enable_out), .alu_opcode_out(alu_opcode_out),
      .alu_input1_out(alu_input1_out), .alu_input2_out(alu_input2_out),
      .alu_output_in(alu_model_q),
      .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
      .resp_result_out(resp_result_out), .resp_opcode_out(resp_opcode_out),
      .resp_error_out(resp_error_out), .op_count_out(op_count_out),
      .error_count_out(error_count_out)
   );

   alu_op_sequencer #(.DATA_WIDTH(8), .ALU_LATENCY(2), .COUNT_WIDTH(4)) dut_small (
      .clock_in(clock_in), .reset_in(reset_in),
      .req_valid_in(req_valid_in), .req_ready_out(s_req_ready),
      .req_opcode_in(req_opcode_in), .req_a_in(req_a_in), .req_b_in(req_b_in),
      .alu_enable_out(s_alu_enable), .alu_opcode_out(s_alu_opcode),
      .alu_input1_out(s_alu_input1), .alu_input2_out(s_alu_input2),
      .alu_output_in(alu_model_q),
      .resp_valid_out(s_resp_valid), .resp_ready_in(resp_ready_in),
      .resp_result_out(s_resp_result), .resp_opcode_out(s_resp_opcode),
      .resp_error_out(s_resp_error), .op_count_out(s_op_count),
      .error_count_out(s_error_count)
   );

   function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a * b;
         3'b011:  return {7'b0, a == b};
         3'b100:  return {7'b0, $signed(a) > $signed(b)};
         default: return 8'h00;
      endcase
   endfunction

   // ALU stand-in: result valid one edge after its inputs change.
   always_ff @(posedge clock_in) alu_model_q <= alu_ref(alu_opcode_out, alu_input1_out, alu_input2_out);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_in);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      for (int i = 0; i < 20 && !req_ready_out; i++) step();
      check("req_ready_before_send", req_ready_out, 1);
      req_valid_in  = 1'b1;
      req_opcode_in = op;
      req_a_in      = a;
      req_b_in      = b;
      step();
      req_valid_in  = 1'b0;
   endtask

   initial begin
      reset_in = 1'b0; req_valid_in = 1'b0; req_opcode_in = '0;
      req_a_in = '0; req_b_in = '0; resp_ready_in = 1'b0;
      step(); step();
      check("rst_req_ready", req_ready_out, 1);
      check("rst_alu_enable", alu_enable_out, 0);
      check("rst_alu_ins", {alu_opcode_out, alu_input1_out, alu_input2_out}, 0);
      check("rst_resp", {resp_valid_out, resp_result_out, resp_opcode_out, resp_error_out}, 0);
      check("rst_counts", {op_count_out, error_count_out}, 0);
      reset_in = 1'b1;
      step();

      // add 0x7F + 0x01, consumer not ready yet
      send(3'b000, 8'h7F, 8'h01);
      check("add_e0_enable", alu_enable_out, 1);
      check("add_e0_ready", req_ready_out, 0);
      check("add_e0_alu_ins", {alu_opcode_out, alu_input1_out, alu_input2_out}, {3'b000, 8'h7F, 8'h01});
      check("add_e0_valid", resp_valid_out, 0);
      step();
      check("add_e1_enable", alu_enable_out, 1);
      check("add_e1_valid", resp_valid_out, 0);
      step();
      check("add_e2_valid", resp_valid_out, 1);
      check("add_e2_enable", alu_enable_out, 0);
      check("add_result", {resp_result_out, resp_opcode_out, resp_error_out}, {8'h80, 3'b000, 1'b0});
      check("add_count_before_hs", op_count_out, 0);
      resp_ready_in = 1'b1;
      step();
      exp_ops++;
      check("add_valid_after_hs", resp_valid_out, 0);
      check("add_op_count", op_count_out, exp_ops);
      check("add_ready_after_hs", req_ready_out, 1);

      // mul -3*5 then gt -128>127, consumer always ready
      send(3'b010, 8'hFD, 8'h05);
      check("mul_ready_c0", req_ready_out, 0);
      step();
      check("mul_ready_c1", req_ready_out, 0);
      step();
      check("mul_ready_c2", req_ready_out, 0);
      check("mul_result", {resp_valid_out, resp_result_out, resp_opcode_out}, {1'b1, 8'hF1, 3'b010});
      step();
      exp_ops++;
      check("mul_ready_back", req_ready_out, 1);
      send(3'b100, 8'h80, 8'h7F);
      check("gt_ready_c0", req_ready_out, 0);
      step();
      check("gt_ready_c1", req_ready_out, 0);
      step();
      check("gt_ready_c2", req_ready_out, 0);
      check("gt_result", {resp_valid_out, resp_result_out, resp_opcode_out}, {1'b1, 8'h00, 3'b100});
      step();
      exp_ops++;
      check("gt_ready_back", req_ready_out, 1);
      check("gt_op_count", op_count_out, exp_ops);

      // illegal opcode 110 bypasses the ALU
      resp_ready_in = 1'b0;
      send(3'b110, 8'h11, 8'h22);
      check("ill_valid", resp_valid_out, 1);
      check("ill_resp", {resp_result_out, resp_opcode_out, resp_error_out}, {8'h00, 3'b110, 1'b1});
      check("ill_enable", alu_enable_out, 0);
      check("ill_err_count", error_count_out, 1);
      check("ill_alu_untouched", {alu_opcode_out, alu_input1_out, alu_input2_out}, {3'b100, 8'h80, 8'h7F});
      resp_ready_in = 1'b1;
      step();
      exp_ops++;
      check("ill_valid_after_hs", resp_valid_out, 0);

      saw_enable = 1'b0;
      for (int i = 0; i < 256; i++) begin
         send(3'b110, 8'(i), 8'h00);
         saw_enable = saw_enable | alu_enable_out;
         check("ill_loop_valid", resp_valid_out, 1);
         step();
         saw_enable = saw_enable | alu_enable_out;
         exp_ops++;
         if (exp_ops == 16) check("small_count_wrap", s_op_count, 0);
      end
      check("ill_loop_no_enable", saw_enable, 0);
      check("ill_err_saturate", error_count_out, 8'hFF);
      check("ill_loop_op_count", op_count_out, exp_ops);
      check("small_count_mod16", s_op_count, 4'(exp_ops));

      // eq 5==5 with consumer stalled for 10 cycles
      resp_ready_in = 1'b0;
      send(3'b011, 8'h05, 8'h05);
      step();
      step();
      for (int i = 0; i < 10; i++) begin
         check("eq_stall_valid", resp_valid_out, 1);
         check("eq_stall_result", {resp_result_out, resp_opcode_out, resp_error_out}, {8'h01, 3'b011, 1'b0});
         check("eq_stall_ready", req_ready_out, 0);
         check("eq_stall_op_count", op_count_out, exp_ops);
         step();
      end
      resp_ready_in = 1'b1;
      step();
      exp_ops++;
      check("eq_op_count", op_count_out, exp_ops);

      // async reset in the middle of WAIT for sub 0x10-0x20
      send(3'b001, 8'h10, 8'h20);
      #2;
      reset_in = 1'b0;
      #1;
      check("arst_req_ready", req_ready_out, 1);
      check("arst_outputs", {alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out,
                             resp_valid_out, resp_result_out, resp_opcode_out, resp_error_out}, 0);
      check("arst_counts", {op_count_out, error_count_out}, 0);
      #2;
      reset_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("arst_no_response", resp_valid_out, 0);
      end
      send(3'b000, 8'h01, 8'h01);
      step();
      step();
      check("post_rst_add", {resp_valid_out, resp_result_out}, {1'b1, 8'h02});
      step();
      check("post_rst_op_count", op_count_out, 1);
      check("small_final", {s_req_ready, s_alu_enable, s_alu_opcode, s_alu_input1, s_alu_input2,
                            s_resp_valid, s_resp_result, s_resp_opcode, s_resp_error,
                            s_error_count, s_op_count},
                           {1'b1, 1'b0, 3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 3'b000, 1'b0, 8'h00, 4'h1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
